// File: rtl/demux_1ton_stream_if.sv
// Stream bus for the 1-to-N demultiplexer: one upstream port, N downstream channels.
interface demux_1ton_stream_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = (N < 2) ? 1 : $clog2(N);

    // Upstream beat
    logic [W-1:0]   i_data;
    logic           i_valid;
    logic           i_last;
    logic [SW-1:0]  sel;
    logic           i_ready;

    // Downstream channels, channel k data in bits [k*W +: W]
    logic [N*W-1:0] y_data;
    logic [N-1:0]   y_valid;
    logic [N-1:0]   y_last;
    logic [N-1:0]   y_ready;

    // Environment side: produces beats and downstream ready
    modport master (
        output i_data, i_valid, i_last, sel, y_ready,
        input  i_ready, y_data, y_valid, y_last
    );

    // Demux side
    modport slave (
        input  i_data, i_valid, i_last, sel, y_ready,
        output i_ready, y_data, y_valid, y_last
    );
endinterface

// File: rtl/demux_1ton_stream.sv
// Packet-aware 1-to-N stream demultiplexer with a single output register.
// The destination is sampled on a packet's first beat and held for the rest
// of the packet; packets addressed to a non-existent channel are discarded
// and counted in a saturating drop counter.
module demux_1ton_stream #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_1ton_stream_if.slave      bus,
    output logic [15:0]             drop_cnt
);
    localparam int unsigned SW = (N < 2) ? 1 : $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PASS = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [SW-1:0]  ch_q;
    logic [SW-1:0]  ch_nxt;

    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_ch;

    logic           sel_ok_c;
    logic [N-1:0]   rdy_match_c;
    logic           out_ready_c;
    logic           ready_c;
    logic           accept_c;
    logic           pop_c;
    logic           load_c;
    logic [SW-1:0]  load_ch_c;
    logic           drop_c;

    logic [N-1:0]   y_valid_c;
    logic [N-1:0]   y_last_c;
    logic [N*W-1:0] y_data_c;

    // Destination index addresses an existing channel
    always_comb sel_ok_c = (32'(bus.sel) < N);

    // Ready of the channel currently holding the buffered beat
    for (genvar k = 0; k < int'(N); k++) begin : g_rdy
        assign rdy_match_c[k] = bus.y_ready[k] && (out_ch == SW'(k));
    end
    always_comb out_ready_c = |rdy_match_c;

    // Upstream handshake: discard state never stalls, otherwise wait for a free register
    always_comb begin
        ready_c  = (state == S_DROP) ? 1'b1 : (!out_valid || out_ready_c);
        accept_c = bus.i_valid && ready_c;
        pop_c    = out_valid && out_ready_c;
    end

    assign bus.i_ready = ready_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ch_q  <= '0;
        end else begin
            state <= state_nxt;
            ch_q  <= ch_nxt;
        end
    end

    // Next state, channel latch and load/drop decisions
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch_q;
        load_c    = 1'b0;
        load_ch_c = ch_q;
        drop_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (sel_ok_c) begin
                        load_c    = 1'b1;
                        load_ch_c = bus.sel;
                        ch_nxt    = bus.sel;
                        state_nxt = bus.i_last ? S_IDLE : S_PASS;
                    end else begin
                        drop_c    = 1'b1;
                        state_nxt = bus.i_last ? S_IDLE : S_DROP;
                    end
                end
            end
            S_PASS: begin
                if (accept_c) begin
                    load_c    = 1'b1;
                    load_ch_c = ch_q;
                    if (bus.i_last) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (accept_c && bus.i_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output register: reload on accept, empty on transfer without accept, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_data  <= bus.i_data;
            out_last  <= bus.i_last;
            out_ch    <= load_ch_c;
        end else if (pop_c) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of discarded packets
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_c && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // Decode the single output register onto the addressed channel only
    for (genvar k = 0; k < int'(N); k++) begin : g_out
        assign y_valid_c[k]       = out_valid && (out_ch == SW'(k));
        assign y_last_c[k]        = out_valid && out_last && (out_ch == SW'(k));
        assign y_data_c[k*W +: W] = (out_ch == SW'(k)) ? out_data : '0;
    end

    assign bus.y_valid = y_valid_c;
    assign bus.y_last  = y_last_c;
    assign bus.y_data  = y_data_c;

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Scoreboard bench: a 4-channel and a 3-channel demux share clock and reset.
`timescale 1ns/1ps
module tb_demux_1ton_stream;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] drop4;
    logic [15:0] drop3;

    int checks;
    int failures;

    exp_t q4[$];
    exp_t q3[$];

    demux_1ton_stream_if #(.N(4), .W(8)) bus4 ();
    demux_1ton_stream_if #(.N(3), .W(8)) bus3 ();

    demux_1ton_stream #(.N(4), .W(8)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus4),
        .drop_cnt (drop4)
    );

    demux_1ton_stream #(.N(3), .W(8)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus3),
        .drop_cnt (drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] data,
                         input logic last, input logic [1:0] s);
        if (d == 0) begin
            bus4.i_valid = v;
            bus4.i_data  = data;
            bus4.i_last  = last;
            bus4.sel     = s;
        end else begin
            bus3.i_valid = v;
            bus3.i_data  = data;
            bus3.i_last  = last;
            bus3.sel     = s;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus4.i_ready : bus3.i_ready;
    endfunction

    task automatic push(input int d, input int ch, input logic [7:0] data, input logic last);
        exp_t e;
        e.ch = ch;
        e.data = data;
        e.last = last;
        if (d == 0) q4.push_back(e);
        else        q3.push_back(e);
    endtask

    // Present one beat, wait (bounded) for acceptance, then go idle; exp_ch < 0 means dropped
    task automatic send(input int d, input logic [7:0] data, input logic [1:0] s,
                        input logic last, input int exp_ch);
        int n;
        drive(d, 1'b1, data, last, s);
        if (exp_ch >= 0) push(d, exp_ch, data, last);
        n = 0;
        @(negedge clk);
        while (!rdy(d) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(d)) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut=%0d actual=not_ready required=ready", d);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 8'h00, 1'b0, 2'd0);
    endtask

    // Monitor for the 4-channel instance
    always @(negedge clk) begin
        if (!rst && bus4.y_valid != '0) begin
            int ch;
            exp_t e;
            ch = 0;
            chk("dut4_onehot", 32'($countones(bus4.y_valid)), 32'd1);
            for (int k = 0; k < 4; k++) if (bus4.y_valid[k]) ch = k;
            if (bus4.y_ready[ch]) begin
                if (q4.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut4_unexpected actual=ch%0d/%h required=none", ch, bus4.y_data[ch*8 +: 8]);
                end else begin
                    e = q4.pop_front();
                    chk("dut4_ch", 32'(ch), 32'(e.ch));
                    chk("dut4_data", 32'(bus4.y_data[ch*8 +: 8]), 32'(e.data));
                    chk("dut4_last", 32'(bus4.y_last[ch]), 32'(e.last));
                    for (int k = 0; k < 4; k++)
                        if (k != ch) chk("dut4_other_slice", 32'(bus4.y_data[k*8 +: 8]), 32'd0);
                end
            end
        end
    end

    // Monitor for the 3-channel instance
    always @(negedge clk) begin
        if (!rst && bus3.y_valid != '0) begin
            int ch;
            exp_t e;
            ch = 0;
            chk("dut3_onehot", 32'($countones(bus3.y_valid)), 32'd1);
            for (int k = 0; k < 3; k++) if (bus3.y_valid[k]) ch = k;
            if (bus3.y_ready[ch]) begin
                if (q3.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut3_unexpected actual=ch%0d/%h required=none", ch, bus3.y_data[ch*8 +: 8]);
                end else begin
                    e = q3.pop_front();
                    chk("dut3_ch", 32'(ch), 32'(e.ch));
                    chk("dut3_data", 32'(bus3.y_data[ch*8 +: 8]), 32'(e.data));
                    chk("dut3_last", 32'(bus3.y_last[ch]), 32'(e.last));
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0, 2'd0);
        drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
        bus4.y_ready = 4'hF;
        bus3.y_ready = 3'b111;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y_valid4", 32'(bus4.y_valid), 32'd0);
        chk("rst_y_last4", 32'(bus4.y_last), 32'd0);
        chk("rst_y_data4", 32'(bus4.y_data), 32'd0);
        chk("rst_i_ready4", 32'(bus4.i_ready), 32'd1);
        chk("rst_drop4", 32'(drop4), 32'd0);
        chk("rst_y_valid3", 32'(bus3.y_valid), 32'd0);
        chk("rst_i_ready3", 32'(bus3.i_ready), 32'd1);
        chk("rst_drop3", 32'(drop3), 32'd0);
        rst = 1'b0;
        cyc();

        // Single-beat routing to channel 2
        send(0, 8'hA5, 2'd2, 1'b1, 2);
        @(negedge clk);
        chk("single_y_valid", 32'(bus4.y_valid), 32'h4);
        chk("single_y_last", 32'(bus4.y_last), 32'h4);
        chk("single_y_data", 32'(bus4.y_data), 32'h00A5_0000);
        cyc();

        // Channel latched on first beat, later sel ignored
        send(0, 8'h11, 2'd1, 1'b0, 1);
        send(0, 8'h22, 2'd3, 1'b0, 1);
        send(0, 8'h33, 2'd3, 1'b1, 1);
        send(0, 8'h44, 2'd0, 1'b1, 0);
        cyc();

        // Backpressure on channel 0, then back-to-back streaming
        bus4.y_ready = 4'b1110;
        send(0, 8'h40, 2'd0, 1'b0, 0);
        drive(0, 1'b1, 8'h41, 1'b0, 2'd3);
        push(0, 0, 8'h41, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_i_ready", 32'(bus4.i_ready), 32'd0);
            chk("bp_data_stable", 32'(bus4.y_data[7:0]), 32'h40);
            chk("bp_y_valid", 32'(bus4.y_valid), 32'h1);
            cyc();
        end
        bus4.y_ready = 4'hF;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus4.i_ready), 32'd1);
        cyc();
        drive(0, 1'b1, 8'h42, 1'b0, 2'd2);
        push(0, 0, 8'h42, 1'b0);
        @(negedge clk);
        chk("stream_ready_b2", 32'(bus4.i_ready), 32'd1);
        cyc();
        drive(0, 1'b1, 8'h43, 1'b1, 2'd1);
        push(0, 0, 8'h43, 1'b1);
        @(negedge clk);
        chk("stream_ready_b3", 32'(bus4.i_ready), 32'd1);
        cyc();
        drive(0, 1'b0, 8'h00, 1'b0, 2'd0);
        cyc();

        // Drop a 2-beat packet to channel 3 on the 3-channel instance
        drive(1, 1'b1, 8'h55, 1'b0, 2'd3);
        @(negedge clk);
        chk("drop_ready_b1", 32'(bus3.i_ready), 32'd1);
        cyc();
        drive(1, 1'b1, 8'h56, 1'b1, 2'd0);
        @(negedge clk);
        chk("drop_ready_b2", 32'(bus3.i_ready), 32'd1);
        chk("drop_y_valid_b2", 32'(bus3.y_valid), 32'd0);
        cyc();
        drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        chk("drop_y_valid_after", 32'(bus3.y_valid), 32'd0);
        chk("drop_cnt_1", 32'(drop3), 32'd1);
        cyc();
        send(1, 8'h77, 2'd0, 1'b1, 0);
        send(1, 8'h78, 2'd2, 1'b0, 2);
        send(1, 8'h79, 2'd0, 1'b1, 2);
        cyc();

        // Invalid sel in IDLE obeys the register-full ready rule
        bus3.y_ready = 3'b110;
        send(1, 8'h60, 2'd0, 1'b1, 0);
        drive(1, 1'b1, 8'h61, 1'b1, 2'd3);
        @(negedge clk);
        chk("bad_sel_stalled", 32'(bus3.i_ready), 32'd0);
        cyc();
        bus3.y_ready = 3'b111;
        @(negedge clk);
        chk("bad_sel_ready", 32'(bus3.i_ready), 32'd1);
        cyc();
        drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        chk("drop_cnt_2", 32'(drop3), 32'd2);
        chk("bad_sel_no_load", 32'(bus3.y_valid), 32'd0);
        cyc();

        // Saturation: 65532 drops take the count from 2 to FFFE
        drive(1, 1'b1, 8'hEE, 1'b1, 2'd3);
        repeat (65532) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(drop3), 32'hFFFE);
        cyc();
        chk("sat_ffff", 32'(drop3), 32'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", 32'(drop3), 32'hFFFF);
        chk("sat_no_valid", 32'(bus3.y_valid), 32'd0);
        drive(1, 1'b0, 8'h00, 1'b0, 2'd0);
        cyc();

        // Reset during beat 2 of a 4-beat packet on channel 1
        send(0, 8'h81, 2'd1, 1'b0, 1);
        drive(0, 1'b1, 8'h82, 1'b0, 2'd2);
        cyc();
        drive(0, 1'b0, 8'h00, 1'b0, 2'd0);
        chk("pre_rst_y_valid", 32'(bus4.y_valid), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_y_valid", 32'(bus4.y_valid), 32'd0);
        chk("mid_rst_y_data", 32'(bus4.y_data), 32'd0);
        chk("mid_rst_i_ready", 32'(bus4.i_ready), 32'd1);
        chk("mid_rst_drop3", 32'(drop3), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        send(0, 8'h90, 2'd2, 1'b0, 2);
        send(0, 8'h91, 2'd1, 1'b1, 2);
        send(0, 8'h92, 2'd3, 1'b1, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
